// File: rtl/cfg_conv_apb_if.sv
// -----------------------------------------------------------------------------
// cfg_conv_apb_if
// APB3 bus bundle between an APB initiator and the APB interconnect.
//   paddr/psel/penable/pwrite/pwdata : driven by the initiator (master)
//   prdata/pready/pslverr            : driven by the completer (slave)
// Modports:
//   master : APB initiator view (cfg_conv_apb)
//   slave  : completer / interconnect view
// -----------------------------------------------------------------------------
interface cfg_conv_apb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/cfg_conv_apb.sv
// -----------------------------------------------------------------------------
// cfg_conv_apb
// APB3 initiator bridge: turns single-cycle cfg-bus write/read strobes into
// APB SETUP/ACCESS transfers and reports completion, read data and error.
//
// Ports:
//   i_apb_clk, i_apb_rst  : clock, synchronous active-high reset
//   i_cfg_wr_en/rd_en     : request strobes (write wins if both high)
//   i_cfg_addr/wr_data    : request address / write data
//   o_cfg_ready           : idle; a strobe this cycle is accepted
//   o_cfg_done            : one-cycle pulse at transfer end
//   o_cfg_rd_vld          : one-cycle pulse, read data valid (reads)
//   o_cfg_rd_data         : last captured read data
//   o_cfg_err             : one-cycle pulse with done on PSLVERR/timeout
//   apb                   : APB3 bus (cfg_conv_apb_if.master)
//
// Build option:
//   APB_CONV_TIMEOUT_EN   : abort an ACCESS phase after TIMEOUT_CYCLES
//                           cycles without PREADY (done+err, read data 0).
// -----------------------------------------------------------------------------
module cfg_conv_apb #(
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int CFG_DATA_WIDTH = 32,
    parameter int CFG_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      i_apb_clk,
    input  logic                      i_apb_rst,
    input  logic                      i_cfg_wr_en,
    input  logic                      i_cfg_rd_en,
    input  logic [CFG_ADDR_WIDTH-1:0] i_cfg_addr,
    input  logic [CFG_DATA_WIDTH-1:0] i_cfg_wr_data,
    output logic                      o_cfg_ready,
    output logic                      o_cfg_done,
    output logic                      o_cfg_rd_vld,
    output logic [CFG_DATA_WIDTH-1:0] o_cfg_rd_data,
    output logic                      o_cfg_err,
    cfg_conv_apb_if.master            apb
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e                    state_q;
    logic                      ready_q;
    logic                      done_q;
    logic                      rd_vld_q;
    logic                      err_q;
    logic [CFG_DATA_WIDTH-1:0] rd_data_q;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic                      psel_q;
    logic                      penable_q;
    logic                      pwrite_q;
    logic [APB_DATA_WIDTH-1:0] pwdata_q;

`ifdef APB_CONV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Last count value before the abort fires: the TIMEOUT_CYCLES-th
    // consecutive ACCESS cycle without PREADY ends the transfer.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt_q;
`endif

    // A zero timeout has no meaning; this block only exists for that case.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_invalid
    end

    // Width adaptation: size casts zero-extend narrower and keep the LSBs
    // of wider sources.
    function automatic logic [APB_ADDR_WIDTH-1:0] to_apb_addr(input logic [CFG_ADDR_WIDTH-1:0] a);
        return APB_ADDR_WIDTH'(a);
    endfunction

    function automatic logic [APB_DATA_WIDTH-1:0] to_apb_data(input logic [CFG_DATA_WIDTH-1:0] d);
        return APB_DATA_WIDTH'(d);
    endfunction

    function automatic logic [CFG_DATA_WIDTH-1:0] to_cfg_data(input logic [APB_DATA_WIDTH-1:0] d);
        return CFG_DATA_WIDTH'(d);
    endfunction

    // Transfer FSM with all cfg and APB outputs registered.
    always_ff @(posedge i_apb_clk) begin
        if (i_apb_rst) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            rd_vld_q  <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
            paddr_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
`ifdef APB_CONV_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            // Status outputs are single-cycle pulses unless set below.
            done_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_cfg_wr_en || i_cfg_rd_en) begin
                        // Write has priority: the read strobe is dropped.
                        paddr_q   <= to_apb_addr(i_cfg_addr);
                        pwdata_q  <= to_apb_data(i_cfg_wr_data);
                        pwrite_q  <= i_cfg_wr_en;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        ready_q   <= 1'b0;
                        state_q   <= ST_SETUP;
`ifdef APB_CONV_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end else begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        ready_q   <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (apb.pready) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        ready_q   <= 1'b1;
                        done_q    <= 1'b1;
                        rd_vld_q  <= ~pwrite_q;
                        err_q     <= apb.pslverr;
                        if (!pwrite_q) begin
                            rd_data_q <= to_cfg_data(apb.prdata);
                        end else begin
                            rd_data_q <= rd_data_q;
                        end
                        state_q   <= ST_IDLE;
                    end
`ifdef APB_CONV_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_LAST) begin
                        // Abort: the read result of a timed-out transfer is 0.
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        ready_q   <= 1'b1;
                        done_q    <= 1'b1;
                        rd_vld_q  <= ~pwrite_q;
                        err_q     <= 1'b1;
                        if (!pwrite_q) begin
                            rd_data_q <= '0;
                        end else begin
                            rd_data_q <= rd_data_q;
                        end
                        state_q   <= ST_IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                        state_q   <= ST_ACCESS;
                    end
`else
                    else begin
                        state_q <= ST_ACCESS;
                    end
`endif
                end
                default: begin
                    state_q   <= ST_IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    ready_q   <= 1'b1;
                end
            endcase
        end
    end

    assign o_cfg_ready   = ready_q;
    assign o_cfg_done    = done_q;
    assign o_cfg_rd_vld  = rd_vld_q;
    assign o_cfg_rd_data = rd_data_q;
    assign o_cfg_err     = err_q;
    assign apb.paddr     = paddr_q;
    assign apb.psel      = psel_q;
    assign apb.penable   = penable_q;
    assign apb.pwrite    = pwrite_q;
    assign apb.pwdata    = pwdata_q;

endmodule

// File: tb/tb_cfg_conv_apb.sv
// -----------------------------------------------------------------------------
// tb_cfg_conv_apb
// Directed, table-driven bench for cfg_conv_apb with hand-computed expected
// values, plus hand-written sequences for idle behaviour, timeout and reset.
// -----------------------------------------------------------------------------
module tb_cfg_conv_apb;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        rd_vld;
    logic [31:0] rd_data;
    logic        err;

    int total = 0;
    int bad   = 0;

    cfg_conv_apb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    cfg_conv_apb #(
        .APB_DATA_WIDTH(32),
        .APB_ADDR_WIDTH(32),
        .CFG_DATA_WIDTH(32),
        .CFG_ADDR_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .i_apb_clk    (clk),
        .i_apb_rst    (rst),
        .i_cfg_wr_en  (wr_en),
        .i_cfg_rd_en  (rd_en),
        .i_cfg_addr   (addr),
        .i_cfg_wr_data(wdata),
        .o_cfg_ready  (ready),
        .o_cfg_done   (done),
        .o_cfg_rd_vld (rd_vld),
        .o_cfg_rd_data(rd_data),
        .o_cfg_err    (err),
        .apb          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] a;
        logic [31:0] wd;
        int          waits;
        logic [31:0] prd;
        logic        slv;
        logic        noise;
        logic        exp_pwrite;
        logic        exp_rd_vld;
        logic        exp_err;
        logic [31:0] exp_rd_data;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered at a negedge of a cycle where the bridge should be idle;
    // returns at the negedge of the done cycle.
    task automatic run_vec(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d_", idx);
        chk({p, "ready_idle"}, 64'(ready), 64'd1);
        wr_en = v.wr;
        rd_en = v.rd;
        addr  = v.a;
        wdata = v.wd;
        cyc();
        // SETUP cycle
        if (v.noise) begin
            wr_en = 1'b1; rd_en = 1'b1; addr = 32'h0000_0999; wdata = 32'h5555_5555;
        end else begin
            wr_en = 1'b0; rd_en = 1'b0;
        end
        chk({p, "setup_psel"},    64'(bus.psel),    64'd1);
        chk({p, "setup_penable"}, 64'(bus.penable), 64'd0);
        chk({p, "paddr"},         64'(bus.paddr),   64'(v.a));
        chk({p, "pwrite"},        64'(bus.pwrite),  64'(v.exp_pwrite));
        if (v.exp_pwrite) chk({p, "pwdata"}, 64'(bus.pwdata), 64'(v.wd));
        chk({p, "setup_ready"},   64'(ready),       64'd0);
        // PREADY/PSLVERR high during SETUP must be ignored
        bus.pready  = 1'b1;
        bus.pslverr = 1'b1;
        cyc();
        for (int k = 0; k <= v.waits; k++) begin
            chk({p, $sformatf("acc%0d_penable", k)}, 64'(bus.penable), 64'd1);
            chk({p, $sformatf("acc%0d_psel", k)},    64'(bus.psel),    64'd1);
            chk({p, $sformatf("acc%0d_paddr", k)},   64'(bus.paddr),   64'(v.a));
            chk({p, $sformatf("acc%0d_done", k)},    64'(done),        64'd0);
            bus.pready  = (k == v.waits);
            bus.pslverr = (k == v.waits) ? v.slv : 1'b1;
            bus.prdata  = (k == v.waits) ? v.prd : 32'hBADD_0000;
            cyc();
        end
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk({p, "done"},      64'(done),        64'd1);
        chk({p, "rd_vld"},    64'(rd_vld),      64'(v.exp_rd_vld));
        chk({p, "err"},       64'(err),         64'(v.exp_err));
        chk({p, "rd_data"},   64'(rd_data),     64'(v.exp_rd_data));
        chk({p, "end_psel"},  64'(bus.psel),    64'd0);
        chk({p, "end_pen"},   64'(bus.penable), 64'd0);
        chk({p, "end_paddr"}, 64'(bus.paddr),   64'(v.a));
    endtask

    initial begin
        //            wr    rd    addr          wdata         wt prdata        slv   noise pwr   rdv   err   rd_data
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, 3, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0024, 32'h0000_0000, 0, 32'hA5A5_0F0F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA5A5_0F0F};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0030, 32'h0BAD_F00D, 1, 32'h7777_7777, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA5A5_0F0F};
        vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 2, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0001, 0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF};

        rst = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
        bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;
        @(negedge clk);
        cyc();
        chk("rst_ready",   64'(ready),       64'd1);
        chk("rst_done",    64'(done),        64'd0);
        chk("rst_rd_vld",  64'(rd_vld),      64'd0);
        chk("rst_err",     64'(err),         64'd0);
        chk("rst_rd_data", 64'(rd_data),     64'd0);
        chk("rst_psel",    64'(bus.psel),    64'd0);
        chk("rst_penable", 64'(bus.penable), 64'd0);
        chk("rst_paddr",   64'(bus.paddr),   64'd0);
        rst = 1'b0;
        cyc();

        // Back-to-back transfers: each starts in the previous done cycle.
        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // Idle: no queued request, APB response lines ignored, pulses cleared.
        bus.pready = 1'b1; bus.pslverr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk($sformatf("idle%0d_psel", i),  64'(bus.psel), 64'd0);
            chk($sformatf("idle%0d_done", i),  64'(done),     64'd0);
            chk($sformatf("idle%0d_err", i),   64'(err),      64'd0);
            chk($sformatf("idle%0d_ready", i), 64'(ready),    64'd1);
            chk($sformatf("idle%0d_paddr", i), 64'(bus.paddr), 64'd0);
        end
        bus.pready = 1'b0; bus.pslverr = 1'b0;

`ifdef APB_CONV_TIMEOUT_EN
        // Read with PREADY held low: abort after 4 ACCESS cycles.
        rd_en = 1'b1; addr = 32'h0000_0050;
        cyc();
        rd_en = 1'b0;
        cyc();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("tmo%0d_penable", k), 64'(bus.penable), 64'd1);
            chk($sformatf("tmo%0d_done", k),    64'(done),        64'd0);
            cyc();
        end
        chk("tmo_done",    64'(done),     64'd1);
        chk("tmo_err",     64'(err),      64'd1);
        chk("tmo_rd_vld",  64'(rd_vld),   64'd1);
        chk("tmo_rd_data", 64'(rd_data),  64'd0);
        chk("tmo_psel",    64'(bus.psel), 64'd0);
        chk("tmo_ready",   64'(ready),    64'd1);
        cyc();
        // Reload nonzero read data so the reset check below is meaningful.
        run_vec(6, vecs[4]);
`else
        // Without a timeout a long wait simply stretches ACCESS.
        begin
            vec_t lw;
            lw = '{1'b0, 1'b1, 32'h0000_0060, 32'h0000_0000, 12, 32'hCAFE_0123, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFE_0123};
            run_vec(6, lw);
        end
`endif
        cyc();

        // Reset during ACCESS: outputs return to reset values, no done pulse.
        rd_en = 1'b1; addr = 32'h0000_0040;
        cyc();
        rd_en = 1'b0;
        cyc();
        chk("rstacc_penable_pre", 64'(bus.penable), 64'd1);
        rst = 1'b1;
        cyc();
        chk("rstacc_psel",    64'(bus.psel),    64'd0);
        chk("rstacc_penable", 64'(bus.penable), 64'd0);
        chk("rstacc_ready",   64'(ready),       64'd1);
        chk("rstacc_done",    64'(done),        64'd0);
        chk("rstacc_rd_vld",  64'(rd_vld),      64'd0);
        chk("rstacc_rd_data", 64'(rd_data),     64'd0);
        chk("rstacc_paddr",   64'(bus.paddr),   64'd0);
        rst = 1'b0;
        bus.pready = 1'b1;
        cyc();
        chk("rstacc_after_done", 64'(done),     64'd0);
        chk("rstacc_after_psel", 64'(bus.psel), 64'd0);
        bus.pready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
